// File: rtl/eve_crossover_engine.sv
// eve_crossover_engine: LFSR-driven byte-wise crossover of parent genes with a paired Rand word, one registered valid/ready stage
module eve_crossover_engine #(
  parameter logic [31:0] SEED_DEFAULT = 32'hACE1_1234
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [63:0] ParentA,
  input  logic [63:0] ParentB,
  input  logic        ParentValid,
  input  logic        ParentLast,
  output logic        ParentReady,
  input  logic [31:0] Config,
  input  logic [31:0] Seed,
  input  logic        SeedLoad,
  output logic [63:0] Crossover,
  output logic [35:0] Rand,
  output logic        CrossoverValid,
  input  logic        CrossoverReady,
  output logic        CrossoverLast,
  output logic [15:0] GeneCount
);
  localparam logic [31:0] MASK = 32'h8020_0003;
  typedef enum logic {EMPTY, FULL} state_t;
  state_t      state_q, state_d;
  logic [31:0] lfsr_q, lfsr_d, lfsr_step;
  logic [35:0] rlfsr_q, rlfsr_d;
  logic [63:0] xover_q, xover_d, mix;
  logic [35:0] rand_q, rand_d;
  logic        last_q, last_d;
  logic [15:0] count_q, count_d;
  logic        acc;
  logic [7:0]  thr;
  logic        unused_cfg;
  assign thr            = Config[7:0];
  assign unused_cfg     = ^Config[31:8];
  assign CrossoverValid = state_q == FULL;
  assign ParentReady    = !SeedLoad && (!CrossoverValid || CrossoverReady);
  assign acc            = ParentValid && ParentReady;
  assign lfsr_step      = (lfsr_q >> 1) ^ (lfsr_q[0] ? MASK : 32'h0);
  assign mix[63:32]     = ParentA[63:32];
  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign mix[8*b +: 8] = (lfsr_q[8*b +: 8] < thr) ? ParentB[8*b +: 8] : ParentA[8*b +: 8];
  end
  always_comb begin
    state_d = acc ? FULL : (CrossoverReady ? EMPTY : state_q);
    xover_d = acc ? mix : xover_q;
    rand_d  = acc ? rlfsr_q : rand_q;
    last_d  = acc ? ParentLast : last_q;
    lfsr_d  = SeedLoad ? ((Seed == 32'h0) ? SEED_DEFAULT : Seed) : (acc ? lfsr_step : lfsr_q);
    rlfsr_d = SeedLoad ? {4'hF, Seed} : (acc ? {rlfsr_q[34:0], rlfsr_q[35] ^ rlfsr_q[24]} : rlfsr_q);
    count_d = SeedLoad ? 16'd0 : (!acc ? count_q : (ParentLast ? 16'd0 : count_q + 16'd1));
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= EMPTY;
      lfsr_q  <= SEED_DEFAULT;
      rlfsr_q <= {4'hF, SEED_DEFAULT};
      xover_q <= 64'h0;
      rand_q  <= 36'h0;
      last_q  <= 1'b0;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      rlfsr_q <= rlfsr_d;
      xover_q <= xover_d;
      rand_q  <= rand_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end
  assign Crossover     = xover_q;
  assign Rand          = rand_q;
  assign CrossoverLast = last_q;
  assign GeneCount     = count_q;
endmodule

// File: doc/eve_crossover_engine.md
# eve_crossover_engine

Produces the `Crossover` gene stream consumed by the EvE perturbation engine. Each accepted parent-gene pair is combined byte-wise from two parent genes under an internal 32-bit LFSR and a crossover threshold, and the result is registered. The block also registers the matching 36-bit `Rand` word, so both perturbation-engine inputs come from one handshake stage. The block sits between parent-genome fetch and the perturbation engine. It carries valid/ready flow control and genome framing.

## Interface
- `SEED_DEFAULT`, 32'hACE1_1234: crossover-LFSR reset and zero-seed fallback value; must be nonzero.
- `Clk` in 1: single clock, rising edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `ParentA` in 64: fitter parent gene; [63:32] gene ID/connection, [31:0] four 8-bit weights.
- `ParentB` in 64: other parent gene, same layout.
- `ParentValid` in 1: parent pair present.
- `ParentLast` in 1: pair is the last gene of the genome.
- `ParentReady` out 1: block accepts the pair this cycle.
- `Config` in 32: [7:0] crossover threshold `T`; [31:8] ignored.
- `Seed` in 32: reseed value.
- `SeedLoad` in 1: reseed request, single cycle.
- `Crossover` out 64: child gene, to perturbation engine.
- `Rand` out 36: random word paired with `Crossover`.
- `CrossoverValid` out 1: output holds a gene.
- `CrossoverReady` in 1: downstream accepts.
- `CrossoverLast` out 1: output gene ends the genome.
- `GeneCount` out 16: genes accepted so far in the current genome.

## Operation
- **Crossover LFSR `L` (32b, Galois).** Mask 32'h8020_0003. Step: `L <= (L>>1) ^ (L[0] ? mask : 0)`.
- **Rand LFSR `R` (36b, Fibonacci).** Taps 36 and 25. Step: `R <= {R[34:0], R[35]^R[24]}`.
- **Accept.** `acc = ParentValid && ParentReady`.
- **`ParentReady`.** Equals `!SeedLoad && (!CrossoverValid || CrossoverReady)`. Throughput is one gene per cycle.
- **On `acc`, using the pre-step `L` and `R`:**
  - `Crossover[63:32] <= ParentA[63:32]`.
  - For byte i = 0..3: `Crossover[8i+7:8i] <= (L[8i+7:8i] < T) ? ParentB byte i : ParentA byte i`. The compare is unsigned. `T` = 0 gives all-A. `T` = 8'hFF selects B unless the LFSR byte is 8'hFF.
  - `Rand <= R`.
  - `CrossoverLast <= ParentLast`.
  - `CrossoverValid <= 1`.
  - `L` and `R` each step once.
- **Output handshake.**
  - Output drain with no accept: `CrossoverValid <= 0`.
  - Drain and accept in the same cycle: the new gene loads and `CrossoverValid` stays 1.
  - While `CrossoverValid && !CrossoverReady`, `Crossover`, `Rand` and `CrossoverLast` hold stable.
- **`GeneCount`.**
  - +1 on each `acc`.
  - On `acc && ParentLast`: `GeneCount <= 0`.
  - Wraps 16'hFFFF → 0.
- **`SeedLoad`.**
  - `L <= (Seed==0) ? SEED_DEFAULT : Seed`.
  - `R <= {4'hF, Seed}`.
  - `GeneCount <= 0`.
  - `ParentReady` is 0 that cycle, so there is no accept.
  - Output register and output handshake are unaffected.
- **Output register control states.**
  - EMPTY (`CrossoverValid`=0) → FULL on `acc`.
  - FULL → EMPTY on `CrossoverReady && !acc`.
  - FULL stays FULL on `acc`, or on `!CrossoverReady`.

## Timing
- **Reset (async assert, sync deassert by top).**
  - `L = SEED_DEFAULT`, `R = {4'hF, SEED_DEFAULT}`.
  - `Crossover = 0`, `Rand = 0`, `CrossoverValid = 0`, `CrossoverLast = 0`, `GeneCount = 0`.
  - `ParentReady` = 1 after reset, unless `SeedLoad` is high.
- **Latency.** One cycle, from accepting edge to `CrossoverValid`/`Crossover`.
- **Mid-operation reset.** Reset mid-operation discards the held gene immediately and clears all outputs to the values above.
- **Zero-seed fallback.** `SeedLoad` with `Seed` = 0 uses `SEED_DEFAULT` for `L`, so `L` never locks up. `R` never reaches zero because its top nibble is F.

## Test plan
- **Reset.** Assert `Reset_n`=0 mid-stream → outputs zero and `CrossoverValid`=0 at once. After release, `ParentReady`=1.
- **Seeded selection.**
  - Stimulus: `SeedLoad` with `Seed`=32'h1, then `T`=8'h01, A=64'hAAAA_AAAA_1111_1111, B=64'hBBBB_BBBB_2222_2222.
  - Next cycle: `Crossover` = 64'hAAAA_AAAA_2222_2211 and `Rand` = 36'hF_0000_0001.
  - Next pair with `T`=8'h04 (`L`=32'h8020_0003) → low word 32'h1111_2222.
- **Pass-through.** `T`=0, 8 random pairs → `Crossover` == `ParentA` every gene.
- **Backpressure.**
  - Hold `CrossoverReady`=0 for 5 cycles with `ParentValid`=1 → `ParentReady`=0, and output is stable and unchanged.
  - Release → one gene per cycle follows, with no loss or duplication (scoreboard on a 20-gene sequence).
- **Framing.** 3-gene genome with `ParentLast` on gene 3 → `GeneCount` reads 1, 2, then 0. `CrossoverLast`=1 only with gene 3.
- **Reseed collision.** `SeedLoad`=1 while `ParentValid`=1 and output is FULL with `CrossoverReady`=1 → no accept that cycle, the held gene drains, and the pair is accepted the following cycle using the new seed.
